// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, FSM states and ALU width.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_OR  = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

   function automatic logic op_legal(logic [2:0] op);
      return op <= OP_SLT;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] ptr;
   logic          found;
   int            j;

   always_comb begin
      grant     = '0;
      grant_idx = ptr;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

   // The winner moves to lowest priority for the next round
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NREQ requesters, one operation in flight.
import alu_pkg::*;

module alu_arbiter #(
   parameter int NREQ   = 2,
   parameter int DATA_W = ALU_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*3-1:0]      req_op,
   input  logic [NREQ*DATA_W-1:0] req_a,
   input  logic [NREQ*DATA_W-1:0] req_b,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]      rsp_result,
   output logic                   rsp_zero,
   output logic                   rsp_err,
   output logic [2:0]             alu_ctrl,
   output logic [DATA_W-1:0]      alu_src_a,
   output logic [DATA_W-1:0]      alu_src_b,
   input  logic [DATA_W-1:0]      alu_result,
   input  logic                   alu_zero
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t        state;
   logic [IW-1:0]     owner;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   logic [NREQ-1:0]   grant;
   logic [IW-1:0]     gidx;
   logic              rsp_done;
   logic              can_accept;
   logic              hs;
   logic [2:0]        sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (hs),
      .grant     (grant),
      .grant_idx (gidx)
   );

   // Completing a response frees the ALU in the same cycle
   assign rsp_done   = (state == RESP) && rsp_ready[owner];
   assign can_accept = rst_n && ((state == IDLE) || rsp_done);
   assign req_ready  = can_accept ? grant : '0;
   assign hs         = |(req_valid & req_ready);

   assign sel_op = req_op[gidx*3 +: 3];
   assign sel_a  = req_a[gidx*DATA_W +: DATA_W];
   assign sel_b  = req_b[gidx*DATA_W +: DATA_W];

   assign alu_ctrl  = op_q;
   assign alu_src_a = a_q;
   assign alu_src_b = b_q;

   always_comb begin
      rsp_valid = '0;
      if (state == RESP) rsp_valid[owner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (hs) begin
            owner <= gidx;
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
         end
         unique case (state)
            IDLE: begin
               if (hs) state <= EXEC;
            end
            EXEC: begin
               // Illegal opcodes never reach the result; the ALU output is ignored
               if (op_legal(op_q)) begin
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
                  rsp_err    <= 1'b0;
               end else begin
                  rsp_result <= '0;
                  rsp_zero   <= 1'b1;
                  rsp_err    <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_done) state <= hs ? EXEC : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
